// File: rtl/s_axis_cc_adapt.sv
// Adapts 128-bit legacy-header completion TLPs to UltraScale CC descriptor beats,
// with length checking and a 2-entry registered skid buffer toward the hard IP.
module s_axis_cc_adapt #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  user_clk,
    input  logic                  user_reset,
    input  logic [DATA_WIDTH-1:0] s_axis_cc_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_cc_tkeep,
    input  logic                  s_axis_cc_tlast,
    input  logic [3:0]            s_axis_cc_tuser,
    input  logic                  s_axis_cc_tvalid,
    output logic                  s_axis_cc_tready,
    output logic [DATA_WIDTH-1:0] s_axis_cc_tdata_a,
    output logic [3:0]            s_axis_cc_tkeep_a,
    output logic                  s_axis_cc_tlast_a,
    output logic [32:0]           s_axis_cc_tuser_a,
    output logic                  s_axis_cc_tvalid_a,
    input  logic [3:0]            s_axis_cc_tready_a
);

    localparam int unsigned CNT_W = 9;
    localparam int unsigned DW1   = 32;
    localparam int unsigned DW2   = 64;

    logic                  sop_q, sop_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  late_q, late_d;
    logic                  v0_q, v0_d, v1_q, v1_d;
    logic                  tready_q, tready_d;
    logic [DATA_WIDTH-1:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
    logic [3:0]            e0_keep_q, e0_keep_d, e1_keep_q, e1_keep_d;
    logic                  e0_last_q, e0_last_d, e1_last_q, e1_last_d;
    logic                  e0_disc_q, e0_disc_d, e1_disc_q, e1_disc_d;

    logic                  has_data;
    logic [9:0]            len;
    logic [10:0]           dw_count;
    logic [11:0]           exp_beats;
    logic [CNT_W-1:0]      load_cnt, dec_cnt, cur_cnt;
    logic [95:0]           desc;
    logic [DATA_WIDTH-1:0] in_data;
    logic [3:0]            in_keep;
    logic                  in_disc, early, late, latched;
    logic                  push, pop;
    logic                  unused_in;

    assign unused_in = ^{s_axis_cc_tkeep, s_axis_cc_tuser[3:1], s_axis_cc_tready_a[3:1]};

    // Header decode into the CC descriptor; only meaningful on sop beats.
    always_comb begin
        has_data    = s_axis_cc_tdata[30];
        len         = s_axis_cc_tdata[9:0];
        dw_count    = has_data ? {(len == 10'd0), len} : 11'd0;
        exp_beats   = has_data ? ((12'(dw_count) + 12'd6) >> 2) : 12'd1;
        load_cnt    = CNT_W'(exp_beats - 12'd1);
        desc        = '0;
        desc[6:0]   = s_axis_cc_tdata[DW2+6:DW2];
        desc[28:16] = {(s_axis_cc_tdata[DW1+11:DW1] == 12'd0), s_axis_cc_tdata[DW1+11:DW1]};
        desc[29]    = (s_axis_cc_tdata[28:24] == 5'b01011);
        desc[42:32] = dw_count;
        desc[45:43] = s_axis_cc_tdata[DW1+15:DW1+13];
        desc[46]    = s_axis_cc_tdata[14];
        desc[63:48] = s_axis_cc_tdata[DW2+31:DW2+16];
        desc[71:64] = s_axis_cc_tdata[DW2+15:DW2+8];
        desc[87:72] = s_axis_cc_tdata[DW1+31:DW1+16];
        desc[91:89] = s_axis_cc_tdata[22:20];
        desc[94:92] = {1'b0, s_axis_cc_tdata[13:12]};
        in_data     = sop_q ? {s_axis_cc_tdata[DATA_WIDTH-1:96], desc} : s_axis_cc_tdata;
        for (int i = 0; i < 4; i++) begin
            in_keep[i] = s_axis_cc_tkeep[4*i];
        end
    end

    // Beat-count check; late tlast is not judged on the sop beat itself.
    always_comb begin
        push    = s_axis_cc_tvalid && tready_q;
        dec_cnt = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        cur_cnt = sop_q ? load_cnt : dec_cnt;
        early   = s_axis_cc_tlast && (cur_cnt != '0);
        late    = !sop_q && !s_axis_cc_tlast && (cur_cnt == '0);
        latched = !sop_q && late_q;
        in_disc = s_axis_cc_tuser[0] | early | late | latched;
        sop_d   = sop_q;
        cnt_d   = cnt_q;
        late_d  = late_q;
        if (push) begin
            if (s_axis_cc_tlast) begin
                sop_d  = 1'b1;
                cnt_d  = '0;
                late_d = 1'b0;
            end else begin
                sop_d  = 1'b0;
                cnt_d  = cur_cnt;
                late_d = latched | late;
            end
        end
    end

    // Skid buffer: entry 0 drives the IP side, entry 1 absorbs one beat of backpressure.
    always_comb begin
        pop       = v0_q && s_axis_cc_tready_a[0];
        v0_d      = v0_q;
        v1_d      = v1_q;
        e0_data_d = e0_data_q;
        e0_keep_d = e0_keep_q;
        e0_last_d = e0_last_q;
        e0_disc_d = e0_disc_q;
        e1_data_d = e1_data_q;
        e1_keep_d = e1_keep_q;
        e1_last_d = e1_last_q;
        e1_disc_d = e1_disc_q;
        if (pop && v1_q) begin
            e0_data_d = e1_data_q;
            e0_keep_d = e1_keep_q;
            e0_last_d = e1_last_q;
            e0_disc_d = e1_disc_q;
            v1_d      = push;
        end else if (pop) begin
            v0_d = push;
        end
        if (push && ((pop && v1_q) || (!pop && v0_q))) begin
            e1_data_d = in_data;
            e1_keep_d = in_keep;
            e1_last_d = s_axis_cc_tlast;
            e1_disc_d = in_disc;
            v1_d      = 1'b1;
        end else if (push) begin
            e0_data_d = in_data;
            e0_keep_d = in_keep;
            e0_last_d = s_axis_cc_tlast;
            e0_disc_d = in_disc;
            v0_d      = 1'b1;
        end
        tready_d = !(v0_d && v1_d);
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            sop_q     <= 1'b1;
            cnt_q     <= '0;
            late_q    <= 1'b0;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            tready_q  <= 1'b0;
            e0_last_q <= 1'b0;
            e0_disc_q <= 1'b0;
            e1_last_q <= 1'b0;
            e1_disc_q <= 1'b0;
        end else begin
            sop_q     <= sop_d;
            cnt_q     <= cnt_d;
            late_q    <= late_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            tready_q  <= tready_d;
            e0_last_q <= e0_last_d;
            e0_disc_q <= e0_disc_d;
            e1_last_q <= e1_last_d;
            e1_disc_q <= e1_disc_d;
        end
    end

    // Datapath payload is qualified by the valid flags, so it carries no reset.
    always_ff @(posedge user_clk) begin
        e0_data_q <= e0_data_d;
        e0_keep_q <= e0_keep_d;
        e1_data_q <= e1_data_d;
        e1_keep_q <= e1_keep_d;
    end

    assign s_axis_cc_tready   = tready_q;
    assign s_axis_cc_tvalid_a = v0_q;
    assign s_axis_cc_tdata_a  = e0_data_q;
    assign s_axis_cc_tkeep_a  = e0_keep_q;
    assign s_axis_cc_tlast_a  = e0_last_q;
    assign s_axis_cc_tuser_a  = {32'd0, e0_disc_q};

endmodule
